nios_system_sysid_checker: RTL
==============================

// Module: nios_system_sysid_checker
// PURPOSE
//  Avalon-MM master sequencer that reads the system-ID slave after reset or on request.
//  Fetches ID (address 1) then timestamp (address 0), compares both against build-time constants
//  and reports match/mismatch/timeout. Sits between reset/boot logic and the sysid control_slave.
//  Gates LEDs / boot hold-off so the FPGA image and Nios software agree before software runs.
// PARAMETERS
//  EXPECTED_ID        32'd1480546884  value the ID word (address 1) must return
//  EXPECTED_TIMESTAMP 32'd0           value the timestamp word (address 0) must return
//  TIMEOUT_CYCLES     8'd255          cycles allowed per read (issue through readdatavalid); >=2
//  MAX_RETRIES        2'd3            full-sequence retries after a timeout before giving up
//  AUTO_START         1'b1            1: run one check automatically on the first cycle after reset release
// PORTS
//  clock              in   1   system clock
//  reset_n            in   1   asynchronous active-low reset
//  start              in   1   1-cycle pulse: begin check; ignored while busy=1
//  avm_address        out  1   sysid word select: 1=ID, 0=timestamp
//  avm_read           out  1   read request, held until accepted
//  avm_waitrequest    in   1   slave stall; read accepted on cycle with avm_read=1 & waitrequest=0
//  avm_readdata       in   32  read data, valid when avm_readdatavalid=1
//  avm_readdatavalid  in   1   read response strobe
//  busy               out  1   1 from cycle after start until done pulse inclusive
//  done               out  1   1-cycle pulse: check finished (pass, mismatch or timeout)
//  id_ok              out  1   last captured ID == EXPECTED_ID
//  ts_ok              out  1   last captured timestamp == EXPECTED_TIMESTAMP
//  timeout_err        out  1   last check exhausted retries
//  id_value           out  32  last captured ID word
//  ts_value           out  32  last captured timestamp word
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, retry count 0, timeout counter 0; reset mid-sequence aborts with no done.
//  FSM: IDLE -> RD_ID -> WT_ID -> RD_TS -> WT_TS -> DONE -> IDLE.
//  IDLE: start (or AUTO_START first cycle after reset) -> RD_ID; clears id_ok/ts_ok/timeout_err/retry cnt.
//  RD_x: avm_read=1, avm_address per word; stays while waitrequest=1; on accept -> WT_x (read drops).
//  WT_x: avm_read=0; readdatavalid -> capture readdata into *_value, register *_ok; next RD or DONE.
//  Single outstanding read only; readdatavalid in any other state ignored (no capture).
//  Readdatavalid in same cycle as acceptance (zero-latency slave) not supported: data taken in WT only.
//  Timeout counter: cleared entering each RD_x, increments every cycle in RD_x/WT_x.
//  Counter reaching TIMEOUT_CYCLES-1 without valid: retry<MAX_RETRIES -> retry++, back to RD_ID
//   (avm_read low >=1 cycle); else timeout_err=1 -> DONE. Valid on that same cycle wins over timeout.
//  Mismatch is not retried; both words always read; id_ok/ts_ok reflect each compare independently.
//  DONE: done=1, busy=1 for exactly one cycle; outputs *_ok/*_value/timeout_err hold until next start.
//  start during busy dropped (not queued); start in DONE cycle also dropped.
// TESTING
//  Slave waitrequest=0, valid 1 cycle after accept, ID=1480546884, TS=0: start@c0 -> read addr1 @c1,
//   addr0 @c3, done@c5, id_ok=1 ts_ok=1 timeout_err=0.
//  ID returns 32'h0000_0001 -> done, id_ok=0, ts_ok=1, id_value=1, no retry (one read per word).
//  waitrequest high 10 cycles on first read -> avm_read/address stable all 10 cycles, then normal pass.
//  Slave never asserts valid, TIMEOUT_CYCLES=16, MAX_RETRIES=3 -> 4 ID read attempts, done, timeout_err=1.
//  reset_n low during WT_TS -> outputs 0 immediately, no done; release with AUTO_START=1 -> fresh pass.
//  start pulsed while busy and spurious readdatavalid in IDLE -> ignored; single done, values unchanged.

Source files
------------

// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read sequencer that fetches the sysid ID and timestamp words after reset or
// on request, compares them with build-time constants and reports pass/mismatch/timeout.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd1480546884,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd0,
    parameter logic [7:0]  TIMEOUT_CYCLES     = 8'd255,
    parameter logic [1:0]  MAX_RETRIES        = 2'd3,
    parameter logic        AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_WT_ID,
        S_RD_TS,
        S_WT_TS,
        S_RETRY,
        S_DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = TIMEOUT_CYCLES - 8'd1;

    state_t      state_q, state_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic        auto_q, auto_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        tmo_hit;
    logic        tmo_evt;

    assign tmo_hit = (tmo_cnt_q >= TMO_LAST);

    always_comb begin
        state_d       = state_q;
        tmo_cnt_d     = tmo_cnt_q;
        retry_d       = retry_q;
        auto_d        = auto_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_err_d = timeout_err_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        tmo_evt       = 1'b0;

        // Saturating so an acceptance right at the limit still times out in the wait state
        if ((state_q == S_RD_ID) || (state_q == S_WT_ID) ||
            (state_q == S_RD_TS) || (state_q == S_WT_TS)) begin
            if (tmo_cnt_q != 8'hFF) begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                auto_d = 1'b0;
                if (start || auto_q) begin
                    state_d       = S_RD_ID;
                    tmo_cnt_d     = 8'd0;
                    retry_d       = 2'd0;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            S_RD_ID: begin
                if (!avm_waitrequest) begin
                    state_d = S_WT_ID;
                end else if (tmo_hit) begin
                    tmo_evt = 1'b1;
                end
            end
            S_WT_ID: begin
                if (avm_readdatavalid) begin
                    id_value_d = avm_readdata;
                    id_ok_d    = (avm_readdata == EXPECTED_ID);
                    state_d    = S_RD_TS;
                    tmo_cnt_d  = 8'd0;
                end else if (tmo_hit) begin
                    tmo_evt = 1'b1;
                end
            end
            S_RD_TS: begin
                if (!avm_waitrequest) begin
                    state_d = S_WT_TS;
                end else if (tmo_hit) begin
                    tmo_evt = 1'b1;
                end
            end
            S_WT_TS: begin
                if (avm_readdatavalid) begin
                    ts_value_d = avm_readdata;
                    ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
                    state_d    = S_DONE;
                end else if (tmo_hit) begin
                    tmo_evt = 1'b1;
                end
            end
            S_RETRY: begin
                // One idle cycle so the slave sees avm_read drop between attempts
                state_d   = S_RD_ID;
                tmo_cnt_d = 8'd0;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo_evt) begin
            if (retry_q < MAX_RETRIES) begin
                retry_d = retry_q + 2'd1;
                state_d = S_RETRY;
            end else begin
                timeout_err_d = 1'b1;
                state_d       = S_DONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            tmo_cnt_q     <= 8'd0;
            retry_q       <= 2'd0;
            auto_q        <= AUTO_START;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            id_value_q    <= 32'd0;
            ts_value_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            retry_q       <= retry_d;
            auto_q        <= auto_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_err_q <= timeout_err_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm_address = (state_q == S_RD_ID);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = timeout_err_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule
